// File: rtl/nes_input_pkg.sv
// Shared definitions for the NES controller input path:
// button bit positions and the dash/jump state encodings.
package nes_input_pkg;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    typedef enum logic [1:0] {
        D_IDLE,
        D_FIRST,
        D_GAP,
        D_DASH
    } dash_state_t;

    typedef enum logic [1:0] {
        J_IDLE,
        J_CHARGE,
        J_HOLD
    } jump_state_t;

endpackage

// File: rtl/dash_detector.sv
// Double-tap dash detector for one direction.
// Ports: clk, reset, sample_valid, press/rel (debounced edges of own
// direction), opp_held (opposite direction level), dash (1-cycle pulse).
module dash_detector
    import nes_input_pkg::*;
#(
    parameter int DASH_WINDOW = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_valid,
    input  logic press,
    input  logic rel,
    input  logic opp_held,
    output logic dash
);

    dash_state_t state;
    logic [3:0]  cnt;
    logic [4:0]  cnt_inc;

    assign cnt_inc = {1'b0, cnt} + 5'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= D_IDLE;
            cnt   <= '0;
            dash  <= 1'b0;
        end else begin
            dash <= 1'b0;
            if (sample_valid) begin
                unique case (state)
                    D_IDLE: begin
                        if (press) state <= D_FIRST;
                    end
                    D_FIRST: begin
                        if (rel) begin
                            state <= D_GAP;
                            cnt   <= '0;
                        end
                    end
                    D_GAP: begin
                        // A blocked second tap restarts the sequence as a first tap.
                        if (press) begin
                            if (opp_held) begin
                                state <= D_FIRST;
                            end else begin
                                state <= D_DASH;
                                dash  <= 1'b1;
                            end
                        end else if (cnt_inc > 5'(DASH_WINDOW)) begin
                            state <= D_IDLE;
                        end else begin
                            cnt <= cnt_inc[3:0];
                        end
                    end
                    D_DASH: begin
                        if (rel) state <= D_IDLE;
                    end
                    default: state <= D_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/player_input.sv
// Debounces the polled NES button byte and decodes fighter actions.
// Ports: clk, reset, buttons_n/sample_valid in; held, pressed, released,
// dash_left/right, jump_short/full, attack, special out (pulses 1 cycle).
module player_input
    import nes_input_pkg::*;
#(
    parameter int DEBOUNCE_SAMPLES  = 2,
    parameter int DASH_WINDOW       = 6,
    parameter int SHORT_HOP_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] buttons_n,
    input  logic       sample_valid,
    output logic [7:0] held,
    output logic [7:0] pressed,
    output logic [7:0] released,
    output logic       dash_left,
    output logic       dash_right,
    output logic       jump_short,
    output logic       jump_full,
    output logic       attack,
    output logic       special
);

    logic [7:0]      raw;
    logic [7:0][2:0] dcnt;
    logic [7:0][2:0] dcnt_nx;
    logic [7:0]      held_nx;
    logic [7:0]      press_nx;
    logic [7:0]      rel_nx;

    jump_state_t     jstate;
    logic [3:0]      jcnt;
    logic [4:0]      jcnt_inc;

    assign raw      = ~buttons_n;
    assign press_nx = held_nx & ~held;
    assign rel_nx   = held & ~held_nx;
    assign jcnt_inc = {1'b0, jcnt} + 5'd1;

    // Post-poll debounce result; committed only on sample_valid.
    always_comb begin
        held_nx = held;
        dcnt_nx = dcnt;
        for (int i = 0; i < 8; i++) begin
            if (raw[i] == held[i]) begin
                dcnt_nx[i] = '0;
            end else if ({1'b0, dcnt[i]} + 4'd1 >= 4'(DEBOUNCE_SAMPLES)) begin
                held_nx[i] = raw[i];
                dcnt_nx[i] = '0;
            end else begin
                dcnt_nx[i] = dcnt[i] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held       <= '0;
            dcnt       <= '0;
            pressed    <= '0;
            released   <= '0;
            attack     <= 1'b0;
            special    <= 1'b0;
            jump_short <= 1'b0;
            jump_full  <= 1'b0;
            jstate     <= J_IDLE;
            jcnt       <= '0;
        end else begin
            pressed    <= '0;
            released   <= '0;
            attack     <= 1'b0;
            special    <= 1'b0;
            jump_short <= 1'b0;
            jump_full  <= 1'b0;
            if (sample_valid) begin
                held     <= held_nx;
                dcnt     <= dcnt_nx;
                pressed  <= press_nx;
                released <= rel_nx;
                attack   <= press_nx[BTN_B] & ~held_nx[BTN_UP];
                special  <= press_nx[BTN_B] & held_nx[BTN_UP];
                unique case (jstate)
                    J_IDLE: begin
                        if (press_nx[BTN_A]) begin
                            jstate <= J_CHARGE;
                            jcnt   <= '0;
                        end
                    end
                    J_CHARGE: begin
                        if (rel_nx[BTN_A]) begin
                            jump_short <= 1'b1;
                            jstate     <= J_IDLE;
                        end else if (jcnt_inc >= 5'(SHORT_HOP_SAMPLES)) begin
                            jump_full <= 1'b1;
                            jstate    <= J_HOLD;
                        end else begin
                            jcnt <= jcnt_inc[3:0];
                        end
                    end
                    J_HOLD: begin
                        if (rel_nx[BTN_A]) jstate <= J_IDLE;
                    end
                    default: jstate <= J_IDLE;
                endcase
            end
        end
    end

    dash_detector #(
        .DASH_WINDOW(DASH_WINDOW)
    ) u_dash_left (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .press       (press_nx[BTN_LEFT]),
        .rel         (rel_nx[BTN_LEFT]),
        .opp_held    (held_nx[BTN_RIGHT]),
        .dash        (dash_left)
    );

    dash_detector #(
        .DASH_WINDOW(DASH_WINDOW)
    ) u_dash_right (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .press       (press_nx[BTN_RIGHT]),
        .rel         (rel_nx[BTN_RIGHT]),
        .opp_held    (held_nx[BTN_LEFT]),
        .dash        (dash_right)
    );

endmodule

// File: tb/tb_player_input.sv
// Bench for player_input: event-level reference model compared every
// cycle, plus literal pulse-count expectations per directed scenario.
module tb_player_input;

    localparam int DEB = 2;
    localparam int WIN = 6;
    localparam int SH  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] buttons_n = 8'hFF;
    logic       sample_valid = 1'b0;
    logic [7:0] held, pressed, released;
    logic       dash_left, dash_right, jump_short, jump_full, attack, special;

    player_input #(
        .DEBOUNCE_SAMPLES (DEB),
        .DASH_WINDOW      (WIN),
        .SHORT_HOP_SAMPLES(SH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .buttons_n   (buttons_n),
        .sample_valid(sample_valid),
        .held        (held),
        .pressed     (pressed),
        .released    (released),
        .dash_left   (dash_left),
        .dash_right  (dash_right),
        .jump_short  (jump_short),
        .jump_full   (jump_full),
        .attack      (attack),
        .special     (special)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    // reference model state
    int         poll;
    int         mdc[8];
    logic [7:0] mheld, e_pr, e_rl;
    logic [5:0] e_act; // {dl, dr, js, jf, att, sp}
    bit         tap[2];
    bit         relv[2];
    int         relp[2];
    bit         jpend;
    int         jstart;

    // DUT pulse counters for literal expectations
    int n_dl, n_dr, n_js, n_jf, n_att, n_sp, n_pa, n_ra;
    int m_js, m_jf, m_dl;

    task automatic check_eq(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [7:0] nh;
        logic [7:0] pr, rl;
        bit hit;
        if (reset) begin
            poll = 0;
            mheld = '0; e_pr = '0; e_rl = '0; e_act = '0;
            for (int i = 0; i < 8; i++) mdc[i] = 0;
            for (int d = 0; d < 2; d++) begin
                tap[d] = 1; relv[d] = 0; relp[d] = 0;
            end
            jpend = 0; jstart = 0;
        end else begin
            e_pr = '0; e_rl = '0; e_act = '0;
            if (sample_valid) begin
                poll++;
                nh = mheld;
                for (int i = 0; i < 8; i++) begin
                    if (!buttons_n[i] == mheld[i]) mdc[i] = 0;
                    else begin
                        mdc[i]++;
                        if (mdc[i] >= DEB) begin
                            nh[i] = !buttons_n[i];
                            mdc[i] = 0;
                        end
                    end
                end
                pr = nh & ~mheld;
                rl = mheld & ~nh;
                e_pr = pr; e_rl = rl;
                mheld = nh;
                // d=0 Right (bit0), d=1 Left (bit1)
                for (int d = 0; d < 2; d++) begin
                    if (pr[d]) begin
                        hit = relv[d] && tap[d] && (poll - relp[d] <= WIN + 1)
                              && !nh[1 - d];
                        tap[d] = !hit;
                        relv[d] = 0;
                        if (d == 1) e_act[5] = hit;
                        else e_act[4] = hit;
                    end
                    if (rl[d] && tap[d]) begin
                        relv[d] = 1;
                        relp[d] = poll;
                    end
                end
                if (jpend && rl[7]) begin
                    e_act[3] = 1; jpend = 0;
                end else if (jpend && poll - jstart >= SH) begin
                    e_act[2] = 1; jpend = 0;
                end
                if (pr[7]) begin
                    jpend = 1; jstart = poll;
                end
                e_act[1] = pr[6] & ~nh[3];
                e_act[0] = pr[6] & nh[3];
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check_eq("held", held, mheld);
            check_eq("pressed", pressed, e_pr);
            check_eq("released", released, e_rl);
            check_eq("actions",
                     {dash_left, dash_right, jump_short, jump_full, attack, special},
                     e_act);
            n_dl += dash_left; n_dr += dash_right;
            n_js += jump_short; n_jf += jump_full;
            n_att += attack; n_sp += special;
            n_pa += pressed[7]; n_ra += released[7];
            m_js += e_act[3]; m_jf += e_act[2]; m_dl += e_act[5];
        end
    end

    task automatic clr_counts();
        n_dl = 0; n_dr = 0; n_js = 0; n_jf = 0;
        n_att = 0; n_sp = 0; n_pa = 0; n_ra = 0;
        m_js = 0; m_jf = 0; m_dl = 0;
    endtask

    task automatic do_poll(input logic [7:0] b, input int n);
        repeat (n) begin
            buttons_n = b;
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        clr_counts();
        @(posedge clk);
        started = 1;
        repeat (2) @(negedge clk);
        check_eq("reset_held", held, 8'h00);
        reset = 1'b0;

        // idle polls
        clr_counts();
        do_poll(8'hFF, 5);
        check_eq("idle_held", held, 8'h00);
        check_eq("idle_pulses", n_dl + n_dr + n_js + n_jf + n_att + n_sp, 0);

        // short hop
        clr_counts();
        do_poll(8'h7F, 2);
        check_eq("a_held_after2", held, 8'h80);
        do_poll(8'hFF, 4);
        check_eq("short_pa", n_pa, 1);
        check_eq("short_js", n_js, 1);
        check_eq("short_jf", n_jf, 0);
        check_eq("model_js", m_js, 1);

        // full jump
        clr_counts();
        do_poll(8'h7F, 7);
        do_poll(8'hFF, 3);
        check_eq("full_jf", n_jf, 1);
        check_eq("full_js", n_js, 0);
        check_eq("full_ra", n_ra, 1);
        check_eq("model_jf", m_jf, 1);

        // left double tap inside window
        clr_counts();
        do_poll(8'hFD, 2);
        do_poll(8'hFF, 3);
        do_poll(8'hFD, 2);
        do_poll(8'hFF, 3);
        check_eq("dash_in_window", n_dl, 1);
        check_eq("model_dl", m_dl, 1);

        // left double tap with too long gap
        clr_counts();
        do_poll(8'hFD, 2);
        do_poll(8'hFF, 8);
        do_poll(8'hFD, 2);
        do_poll(8'hFF, 10);
        check_eq("dash_late", n_dl, 0);

        // right second tap blocked by left held
        clr_counts();
        do_poll(8'hFE, 2);
        do_poll(8'hFF, 3);
        do_poll(8'hFC, 2);
        do_poll(8'hFF, 3);
        check_eq("dash_blocked_r", n_dr, 0);
        check_eq("dash_blocked_l", n_dl, 0);

        // B decode
        clr_counts();
        do_poll(8'hF7, 2);
        do_poll(8'hB7, 2);
        do_poll(8'hFF, 3);
        check_eq("up_b_special", n_sp, 1);
        check_eq("up_b_attack", n_att, 0);
        clr_counts();
        do_poll(8'hBF, 2);
        do_poll(8'hFF, 3);
        check_eq("b_attack", n_att, 1);
        check_eq("b_special", n_sp, 0);

        // reset during dash gap and jump charge
        do_poll(8'hFD, 2);
        do_poll(8'hFF, 2);
        do_poll(8'h7F, 3);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("reset_outs",
                 {held, pressed, released, dash_left, dash_right,
                  jump_short, jump_full, attack, special}, 30'd0);
        reset = 1'b0;
        clr_counts();
        do_poll(8'hFF, 1);
        do_poll(8'hFD, 2);
        do_poll(8'hFF, 2);
        check_eq("post_reset_jump", n_js + n_jf, 0);
        check_eq("post_reset_dash", n_dl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
